// File: rtl/wb_stage_pkg.sv
// Shared encodings for the registered writeback stage and its load extender.
// Also used by the LSU so load funct3 handling stays consistent between the two.
package wb_stage_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Byte-offset bits that must be zero for a naturally aligned access of this type.
    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        logic [2:0] m;
        m = 3'b000;
        case (funct3)
            F3_LH, F3_LHU: m = 3'b001;
            F3_LW, F3_LWU: m = 3'b011;
            F3_LD:         m = 3'b111;
            default:       m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake, data-memory response and writeback port bundle.
// master = upstream pipeline/memory side, slave = the writeback stage.
interface wb_stage_if
    import wb_stage_pkg::*;
#(
    parameter int XLEN   = DATA_WIDTH,
    parameter int REG_AW = 5,
    parameter int OFF_W  = $clog2(XLEN/8)
) ();

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm;
    logic [1:0]        wb_sel;
    logic              reg_write_in;
    logic              kill_wb;
    logic [REG_AW-1:0] rd_in;
    logic [2:0]        load_funct3;
    logic [OFF_W-1:0]  addr_lo;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              wb_valid;
    logic [XLEN-1:0]   rd_wdata;
    logic              reg_write_out;
    logic [REG_AW-1:0] rd_out;
    logic              load_fault;
    logic              busy;

    modport master (
        output in_valid, alu_result, pc_plus4, imm, wb_sel, reg_write_in, kill_wb,
               rd_in, load_funct3, addr_lo, mem_rvalid, mem_rdata,
        input  in_ready, wb_valid, rd_wdata, reg_write_out, rd_out, load_fault, busy
    );

    modport slave (
        input  in_valid, alu_result, pc_plus4, imm, wb_sel, reg_write_in, kill_wb,
               rd_in, load_funct3, addr_lo, mem_rvalid, mem_rdata,
        output in_ready, wb_valid, rd_wdata, reg_write_out, rd_out, load_fault, busy
    );

endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load aligner: shifts the raw word down by the byte offset, then
// sign/zero-extends; misaligned or illegal (for this XLEN) loads fault with zero data.
module load_extend
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = DATA_WIDTH,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  raw,
    output logic [XLEN-1:0]  data,
    output logic             fault
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;
    logic            illegal;
    logic            misaligned;

    assign shifted    = raw >> {offset, 3'b000};
    assign misaligned = |(offset & OFF_W'(align_mask(funct3)));

    always_comb begin
        ext     = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:  ext = XLEN'($signed(shifted[7:0]));
            F3_LH:  ext = XLEN'($signed(shifted[15:0]));
            F3_LW:  ext = XLEN'($signed(shifted[31:0]));
            F3_LBU: ext = XLEN'(shifted[7:0]);
            F3_LHU: ext = XLEN'(shifted[15:0]);
            F3_LD: begin
                if (XLEN == 64) ext = shifted;
                else            illegal = 1'b1;
            end
            F3_LWU: begin
                if (XLEN == 64) ext = XLEN'(shifted[31:0]);
                else            illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault = illegal | misaligned;
    assign data  = fault ? '0 : ext;

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects the result source, waits for load data when
// needed, and drives the register-file write port / WB forwarding source.
//
// state       | meaning
// ST_IDLE     | ready; non-load results retire on the next edge
// ST_WAIT_MEM | load accepted, waiting (unbounded) for mem_rvalid
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN   = DATA_WIDTH,
    parameter int REG_AW = 5,
    parameter int OFF_W  = $clog2(XLEN/8)
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    wb_state_e         state;
    wb_state_e         state_nxt;
    logic              accept;
    logic              take_load;
    logic              in_ready_c;
    logic              busy_c;

    logic [REG_AW-1:0] ld_rd;
    logic              ld_rw;
    logic [2:0]        ld_f3;
    logic [OFF_W-1:0]  ld_off;
    logic [XLEN-1:0]   ext_data;
    logic              ext_fault;

    logic              wb_valid_d, wb_valid_q;
    logic [XLEN-1:0]   wdata_d, wdata_q;
    logic              rw_d, rw_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              fault_d, fault_q;

    assign accept    = bus.in_valid & in_ready_c;
    assign take_load = (bus.wb_sel == WB_MEM) & ~bus.kill_wb;

    load_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extend (
        .funct3 (ld_f3),
        .offset (ld_off),
        .raw    (bus.mem_rdata),
        .data   (ext_data),
        .fault  (ext_fault)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept && take_load) state_nxt = ST_WAIT_MEM;
            ST_WAIT_MEM: if (bus.mem_rvalid)      state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered writeback port; all-zero unless something retires.
    always_comb begin
        in_ready_c = rst_n & (state == ST_IDLE);
        busy_c     = (state == ST_WAIT_MEM);
        wb_valid_d = 1'b0;
        wdata_d    = '0;
        rw_d       = 1'b0;
        rd_d       = '0;
        fault_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && !take_load) begin
                    wb_valid_d = 1'b1;
                    rd_d       = bus.rd_in;
                    rw_d       = bus.reg_write_in & ~bus.kill_wb & (bus.rd_in != '0);
                    case (wb_sel_e'(bus.wb_sel))
                        WB_ALU:  wdata_d = bus.alu_result;
                        WB_PC4:  wdata_d = bus.pc_plus4;
                        WB_IMM:  wdata_d = bus.imm;
                        default: wdata_d = '0;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    rd_d       = ld_rd;
                    fault_d    = ext_fault;
                    wdata_d    = ext_data;
                    rw_d       = ld_rw & (ld_rd != '0) & ~ext_fault;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            rd_q       <= '0;
            fault_q    <= 1'b0;
            ld_rd      <= '0;
            ld_rw      <= 1'b0;
            ld_f3      <= '0;
            ld_off     <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            rd_q       <= rd_d;
            fault_q    <= fault_d;
            if (accept && take_load) begin
                ld_rd  <= bus.rd_in;
                ld_rw  <= bus.reg_write_in;
                ld_f3  <= bus.load_funct3;
                ld_off <= bus.addr_lo;
            end
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.busy          = busy_c;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.rd_wdata      = wdata_q;
    assign bus.reg_write_out = rw_q;
    assign bus.rd_out        = rd_q;
    assign bus.load_fault    = fault_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: drives identical stimulus into an XLEN=32 and an XLEN=64
// instance and compares both against an arithmetic reference model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct {
        logic [1:0]  sel;
        logic        rw;
        logic        kill;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] alu;
        logic [63:0] pc4;
        logic [63:0] imm;
        logic [63:0] rdata;
        int          lat;
        bit          gap;
        logic [31:0] e_data;
        logic        e_rw;
        logic        e_fault;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic        rw;
        logic [4:0]  rd;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [63:0] alu_result, pc_plus4, imm, mem_rdata;
    logic [1:0]  wb_sel;
    logic        reg_write_in, kill_wb, mem_rvalid;
    logic [4:0]  rd_in;
    logic [2:0]  load_funct3, addr_lo;

    int checks = 0;
    int errors = 0;

    wb_stage_if #(.XLEN(32)) bus32 ();
    wb_stage_if #(.XLEN(64)) bus64 ();

    assign bus32.in_valid     = in_valid;
    assign bus32.alu_result   = alu_result[31:0];
    assign bus32.pc_plus4     = pc_plus4[31:0];
    assign bus32.imm          = imm[31:0];
    assign bus32.wb_sel       = wb_sel;
    assign bus32.reg_write_in = reg_write_in;
    assign bus32.kill_wb      = kill_wb;
    assign bus32.rd_in        = rd_in;
    assign bus32.load_funct3  = load_funct3;
    assign bus32.addr_lo      = addr_lo[1:0];
    assign bus32.mem_rvalid   = mem_rvalid;
    assign bus32.mem_rdata    = mem_rdata[31:0];

    assign bus64.in_valid     = in_valid;
    assign bus64.alu_result   = alu_result;
    assign bus64.pc_plus4     = pc_plus4;
    assign bus64.imm          = imm;
    assign bus64.wb_sel       = wb_sel;
    assign bus64.reg_write_in = reg_write_in;
    assign bus64.kill_wb      = kill_wb;
    assign bus64.rd_in        = rd_in;
    assign bus64.load_funct3  = load_funct3;
    assign bus64.addr_lo      = addr_lo;
    assign bus64.mem_rvalid   = mem_rvalid;
    assign bus64.mem_rdata    = mem_rdata;

    wb_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    wb_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    function automatic logic [63:0] xmask(input int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference: access size/signedness from funct3, then plain shift-and-mask arithmetic.
    function automatic exp_t model(input int xlen, input vec_t v);
        exp_t        e;
        int          size;
        bit          sgn;
        bit          legal;
        int          o;
        logic [63:0] w, lo_mask, val;
        e       = '0;
        e.rd    = v.rd;
        size    = 1;
        sgn     = 1'b0;
        legal   = 1'b1;
        if (v.sel == 2'd1 && !v.kill) begin
            case (v.f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: begin size = 4; sgn = 1'b1; end
                3'd3: begin size = 8; legal = (xlen == 64); end
                3'd4: size = 1;
                3'd5: size = 2;
                3'd6: begin size = 4; legal = (xlen == 64); end
                default: legal = 1'b0;
            endcase
            o = int'(v.off) % (xlen / 8);
            if (!legal || (o % size) != 0) begin
                e.fault = 1'b1;
            end else begin
                w = (v.rdata & xmask(xlen)) >> (8 * o);
                if (size == 8) begin
                    val = w;
                end else begin
                    lo_mask = (64'd1 << (8 * size)) - 64'd1;
                    val = w & lo_mask;
                    if (sgn && w[8*size-1]) val = val | ~lo_mask;
                end
                e.data = val & xmask(xlen);
            end
        end else begin
            case (v.sel)
                2'd0:    e.data = v.alu & xmask(xlen);
                2'd2:    e.data = v.pc4 & xmask(xlen);
                2'd3:    e.data = v.imm & xmask(xlen);
                default: e.data = 64'd0;
            endcase
        end
        e.rw = v.rw && !v.kill && (v.rd != 5'd0) && !e.fault;
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] sel, input logic rw, input logic kill,
                                input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                                input logic [63:0] alu, input logic [63:0] pc4, input logic [63:0] imm_v,
                                input logic [63:0] rdata, input int lat, input bit gap,
                                input logic [31:0] e_data, input logic e_rw, input logic e_fault);
        vec_t v;
        v.sel = sel; v.rw = rw; v.kill = kill; v.rd = rd; v.f3 = f3; v.off = off;
        v.alu = alu; v.pc4 = pc4; v.imm = imm_v; v.rdata = rdata; v.lat = lat; v.gap = gap;
        v.e_data = e_data; v.e_rw = e_rw; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic v, input exp_t e32_in, input exp_t e64_in);
        exp_t e32, e64;
        e32 = v ? e32_in : '0;
        e64 = v ? e64_in : '0;
        chk({tag, "/32 wb_valid"},      64'(bus32.wb_valid),      64'(v));
        chk({tag, "/32 rd_wdata"},      64'(bus32.rd_wdata),      e32.data & xmask(32));
        chk({tag, "/32 reg_write_out"}, 64'(bus32.reg_write_out), 64'(e32.rw));
        chk({tag, "/32 rd_out"},        64'(bus32.rd_out),        64'(e32.rd));
        chk({tag, "/32 load_fault"},    64'(bus32.load_fault),    64'(e32.fault));
        chk({tag, "/64 wb_valid"},      64'(bus64.wb_valid),      64'(v));
        chk({tag, "/64 rd_wdata"},      bus64.rd_wdata,           e64.data);
        chk({tag, "/64 reg_write_out"}, 64'(bus64.reg_write_out), 64'(e64.rw));
        chk({tag, "/64 rd_out"},        64'(bus64.rd_out),        64'(e64.rd));
        chk({tag, "/64 load_fault"},    64'(bus64.load_fault),    64'(e64.fault));
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic bsy);
        chk({tag, "/32 in_ready"}, 64'(bus32.in_ready), 64'(rdy));
        chk({tag, "/32 busy"},     64'(bus32.busy),     64'(bsy));
        chk({tag, "/64 in_ready"}, 64'(bus64.in_ready), 64'(rdy));
        chk({tag, "/64 busy"},     64'(bus64.busy),     64'(bsy));
    endtask

    task automatic drive(input vec_t v);
        in_valid     = 1'b1;
        wb_sel       = v.sel;
        reg_write_in = v.rw;
        kill_wb      = v.kill;
        rd_in        = v.rd;
        load_funct3  = v.f3;
        addr_lo      = v.off;
        alu_result   = v.alu;
        pc_plus4     = v.pc4;
        imm          = v.imm;
    endtask

    // Called between edges; returns #1 after the edge at which the result appears.
    task automatic do_op(input vec_t v, input bit use_tbl, input string tag);
        exp_t e32, e64;
        e32 = model(32, v);
        e64 = model(64, v);
        if (use_tbl) begin
            e32.data  = {32'd0, v.e_data};
            e32.rw    = v.e_rw;
            e32.fault = v.e_fault;
        end
        drive(v);
        check_status({tag, " accept"}, 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.sel == 2'd1 && !v.kill) begin
            for (int i = 0; i < v.lat; i++) begin
                check_status({tag, " wait"}, 1'b0, 1'b1);
                chk({tag, " wait/32 wb_valid"}, 64'(bus32.wb_valid), 64'd0);
                chk({tag, " wait/64 wb_valid"}, 64'(bus64.wb_valid), 64'd0);
                in_valid  = 1'($urandom_range(0, 1));
                wb_sel    = 2'($urandom_range(0, 3));
                mem_rdata = {$urandom, $urandom};
                if (i == v.lat - 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = v.rdata;
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
        end
        check_wb(tag, 1'b1, e32, e64);
        if (v.gap) begin
            @(posedge clk); #1;
            check_wb({tag, " gap"}, 1'b0, '0, '0);
        end
    endtask

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        tbl[0]  = mk(2'd0, 1, 0, 5'd10, 3'd0, 3'd0, 64'h5555_0000_A1A1_A1A1, 64'd0, 64'd0, 64'd0, 1, 1,
                     32'hA1A1_A1A1, 1, 0);
        tbl[1]  = mk(2'd1, 1, 0, 5'd5, F3_LB, 3'd3, 64'd0, 64'd0, 64'd0, 64'h0000_0000_80FF_0000, 4, 1,
                     32'hFFFF_FF80, 1, 0);
        tbl[2]  = mk(2'd1, 1, 0, 5'd6, F3_LHU, 3'd2, 64'd0, 64'd0, 64'd0, 64'h0000_0000_8001_1234, 2, 1,
                     32'h0000_8001, 1, 0);
        tbl[3]  = mk(2'd1, 1, 0, 5'd7, F3_LH, 3'd1, 64'd0, 64'd0, 64'd0, 64'h0000_0000_8001_1234, 1, 1,
                     32'h0, 0, 1);
        tbl[4]  = mk(2'd2, 1, 0, 5'd31, 3'd0, 3'd0, 64'd0, 64'hC3C3_C3C3_C3C3_C3C3, 64'd0, 64'd0, 1, 0,
                     32'hC3C3_C3C3, 1, 0);
        tbl[5]  = mk(2'd3, 1, 0, 5'd0, 3'd0, 3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_1234_5000, 64'd0, 1, 0,
                     32'h1234_5000, 0, 0);
        tbl[6]  = mk(2'd0, 1, 1, 5'd3, 3'd0, 3'd0, 64'h0000_0000_DEAD_BEEF, 64'd0, 64'd0, 64'd0, 1, 1,
                     32'hDEAD_BEEF, 0, 0);
        tbl[7]  = mk(2'd1, 1, 0, 5'd8, F3_LWU, 3'd4, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_0000_0000, 3, 1,
                     32'h0, 0, 1);
        tbl[8]  = mk(2'd1, 1, 0, 5'd9, F3_LD, 3'd4, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_0000_0000, 1, 1,
                     32'h0, 0, 1);
        tbl[9]  = mk(2'd1, 1, 0, 5'd11, F3_LW, 3'd0, 64'd0, 64'd0, 64'd0, 64'h0000_0001_8765_4321, 2, 1,
                     32'h8765_4321, 1, 0);
        tbl[10] = mk(2'd1, 1, 0, 5'd12, F3_LBU, 3'd1, 64'd0, 64'd0, 64'd0, 64'h0000_0000_0000_A500, 1, 1,
                     32'h0000_00A5, 1, 0);
        tbl[11] = mk(2'd1, 1, 1, 5'd4, F3_LB, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1,
                     32'h0, 0, 0);
        tbl[12] = mk(2'd0, 0, 0, 5'd9, 3'd0, 3'd0, 64'd5, 64'd0, 64'd0, 64'd0, 1, 1,
                     32'h0000_0005, 0, 0);
        tbl[13] = mk(2'd1, 1, 0, 5'd0, F3_LB, 3'd0, 64'd0, 64'd0, 64'd0, 64'h0000_0000_0000_007F, 1, 1,
                     32'h0000_007F, 0, 0);
        tbl[14] = mk(2'd1, 1, 0, 5'd13, F3_LW, 3'd2, 64'd0, 64'd0, 64'd0, 64'h1111_2222_3333_4444, 2, 1,
                     32'h0, 0, 1);
        tbl[15] = mk(2'd1, 1, 0, 5'd14, F3_LH, 3'd2, 64'd0, 64'd0, 64'd0, 64'h0000_0000_FEDC_0000, 1, 1,
                     32'hFFFF_FEDC, 1, 0);

        rst_n = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        alu_result = '0; pc_plus4 = '0; imm = '0; wb_sel = '0;
        reg_write_in = 1'b0; kill_wb = 1'b0; rd_in = '0; load_funct3 = '0; addr_lo = '0;

        repeat (2) @(posedge clk);
        #1;
        check_status("in reset", 1'b0, 1'b0);
        check_wb("in reset", 1'b0, '0, '0);
        rst_n = 1'b1;
        #1;
        check_status("after reset", 1'b1, 1'b0);

        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check_wb("stray rvalid idle", 1'b0, '0, '0);
        check_status("stray rvalid idle", 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // Reset while a load is outstanding: the late response must be dropped.
        v = mk(2'd1, 1, 0, 5'd15, F3_LB, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 32'h0, 0, 0);
        drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_status("rst pending", 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_status("rst applied", 1'b0, 1'b0);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0000_0000_0000_0055;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check_wb("rst late rvalid", 1'b0, '0, '0);
        check_status("rst late rvalid", 1'b1, 1'b0);
        @(posedge clk); #1;
        check_wb("rst late rvalid+1", 1'b0, '0, '0);

        for (int n = 0; n < 300; n++) begin
            v.sel   = 2'($urandom_range(0, 3));
            v.rw    = 1'($urandom_range(0, 3) != 0);
            v.kill  = 1'($urandom_range(0, 3) == 0);
            v.rd    = 5'($urandom);
            v.f3    = 3'($urandom);
            v.off   = 3'($urandom);
            v.alu   = {$urandom, $urandom};
            v.pc4   = {$urandom, $urandom};
            v.imm   = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.lat   = $urandom_range(1, 4);
            v.gap   = 1'($urandom_range(0, 1));
            do_op(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered writeback stage, successor to the combinational writeback mux.
- Accepts one retiring instruction per handshake from the MEM stage and selects its writeback source (ALU, load data, PC+4 or immediate).
- For loads, waits for a variable-latency data-memory response, then aligns and sign/zero-extends the load data.
- Drives the register-file write port one cycle after the result is available; the registered outputs also act as the WB forwarding source.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (default equals `DATA_WIDTH`).
REG_AW, 5, register index width.
OFF_W, $clog2(XLEN/8), width of the load address byte offset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  MEM stage presents an instruction.
in_ready  out  1  stage can accept; in_valid & in_ready = accept.
alu_result  in  XLEN  ALU result.
pc_plus4  in  XLEN  link value.
imm  in  XLEN  U-type immediate.
wb_sel  in  2  0=ALU, 1=MEM, 2=PC4, 3=IMM.
reg_write_in  in  1  instruction writes rd.
kill_wb  in  1  squash; no architectural write.
rd_in  in  REG_AW  destination register.
load_funct3  in  3  load type.
addr_lo  in  OFF_W  load address byte offset.
mem_rvalid  in  1  load data valid.
mem_rdata  in  XLEN  raw aligned memory word.
wb_valid  out  1  one-cycle pulse: outputs describe a retired instruction.
rd_wdata  out  XLEN  write data.
reg_write_out  out  1  register-file write enable, qualified by wb_valid.
rd_out  out  REG_AW  write index.
load_fault  out  1  one-cycle pulse with wb_valid on a misaligned or illegal load.
busy  out  1  FSM in WAIT_MEM.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs zero, except in_ready=1 once rst_n=1.
  - Any pending load is dropped; a mem_rvalid arriving afterwards is ignored.
- FSM states: IDLE, WAIT_MEM. in_ready = (state==IDLE).
- IDLE, accept, and (wb_sel!=MEM or kill_wb=1):
  - Next edge registers the result.
  - wb_valid=1 for exactly one cycle; stays in IDLE.
  - Latency 1 cycle, back-to-back throughput 1 per cycle.
- IDLE, accept, wb_sel==MEM and kill_wb=0:
  - Latch rd_in, reg_write_in, load_funct3, addr_lo.
  - Go to WAIT_MEM; no wb_valid this cycle.
- WAIT_MEM:
  - in_ready=0.
  - On mem_rvalid: extract load data, assert wb_valid on the next edge, return to IDLE.
  - Wait is unbounded.
  - mem_rvalid seen in IDLE is ignored; same-cycle accept and response is impossible by protocol.
- Source select: ALU→alu_result, PC4→pc_plus4, IMM→imm, MEM→extracted load.
- Load extraction (shift mem_rdata right by addr_lo*8, then extend):
  - 000 LB: sign-extend 8 bits.
  - 001 LH: sign-extend 16 bits.
  - 010 LW: sign-extend 32 bits (XLEN=64); pass-through (XLEN=32).
  - 100 LBU: zero-extend 8 bits.
  - 101 LHU: zero-extend 16 bits.
  - XLEN=64 only: 011 LD pass-through; 110 LWU zero-extend 32 bits.
- Misalignment, when the offset is not a multiple of the access size (half: addr_lo[0]; word: addr_lo[1:0]; double: addr_lo[2:0]):
  - load_fault=1, reg_write_out=0, rd_wdata=0.
  - Illegal funct3 for the current XLEN is handled the same way.
- Write qualification: reg_write_out = reg_write_in & ~kill_wb & (rd!=0) & ~fault, registered alongside the data.
  - A killed instruction still pulses wb_valid, with reg_write_out=0.
- When wb_valid=0, rd_wdata, rd_out and reg_write_out hold 0.

Decomposition:
- Shared package / defines.vh:
  - WB_ALU/WB_MEM/WB_PC4/WB_IMM encodings (2-bit).
  - Load funct3 constants F3_LB..F3_LWU.
  - FSM state encodings.
- One sub-module, load_extend: combinational (funct3, offset, raw word) → (data, fault); XLEN-parametrised and reusable by the LSU.

Test Plan:
- ALU with rd=10, alu_result=A1A1A1A1; accept at cycle 0 → cycle 1: wb_valid=1, rd_wdata=A1A1A1A1, reg_write_out=1, rd_out=10; cycle 2: wb_valid=0.
- LB with addr_lo=3, mem_rvalid 4 cycles after accept, mem_rdata=80FF_0000 → in_ready=0 and busy=1 during the wait; rd_wdata=FFFF_FF80 one cycle after rvalid.
- LHU with addr_lo=2, rdata=8001_1234 → 0000_8001; LH with addr_lo=1 → load_fault=1, reg_write_out=0, wb_valid=1.
- Back-to-back: PC4 (C3C3C3C3, rd=31), IMM (rd=0), ALU with kill_wb=1 → three consecutive wb_valid pulses with reg_write_out=1, 0, 0.
- rst_n=0 while in WAIT_MEM, then mem_rvalid=1 after release → no wb_valid, busy=0, in_ready=1.
- XLEN=64: LWU with addr_lo=4, rdata=FFFFFFFF_00000000 → 00000000_FFFFFFFF; LD with addr_lo=4 → load_fault=1.
